// File: rtl/seg_scan_capture_pkg.sv
// Shared types and helpers for the seven-segment scan capture block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seg_scan_capture_pkg;

    localparam int          DIGIT_W    = 8;
    localparam int          NUM_DIGITS = 8;
    localparam logic [7:0]  COM_BLANK  = 8'hFF;

    typedef enum logic {
        SYNC,
        COLLECT
    } state_e;

    // Digit i lives at [8i+7:8i] of the flattened 64-bit word.
    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] frame_t;

    typedef struct packed {
        logic       one_low;  // exactly one COM bit is low
        logic [2:0] idx;      // index of the (highest) low bit
    } com_dec_t;

    // Maps an active-low digit select to a digit index and flags whether
    // exactly one line was low.
    function automatic com_dec_t com_decode(input logic [NUM_DIGITS-1:0] com);
        com_dec_t    r;
        int unsigned n_low;
        r     = '0;
        n_low = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!com[i]) begin
                r.idx = 3'(i);
                n_low++;
            end
        end
        r.one_low = (n_low == 1);
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_capture_input_deglitch.sv
// seg_input_deglitch: registers COM/ENS, counts stable samples, strobes one accept per new digit.
// Latency: accept strobe SETTLE+1 cycles after the inputs change (combinational strobe off registered state).
// Backpressure: none; accepts are single-cycle strobes the consumer must take.
// Ports: clk, nrst | com_in/ens_in raw scan lines | acc_vld strobe with acc_com/acc_ens.
module seg_input_deglitch
    import seg_scan_capture_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [7:0]         com_in,
    input  logic [DIGIT_W-1:0] ens_in,
    output logic               acc_vld,
    output logic [7:0]         acc_com,
    output logic [DIGIT_W-1:0] acc_ens
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    logic [7:0]         com_q, prev_com_q, last_com_q, last_com_d;
    logic [DIGIT_W-1:0] ens_q, prev_ens_q;
    logic [3:0]         cnt_q, cnt_d;
    logic               stable, settled;

    assign stable  = (com_q == prev_com_q) && (ens_q == prev_ens_q);
    // True only on the one cycle the counter steps onto SETTLE.
    assign settled = stable && (cnt_q == SETTLE_C - 4'd1);

    always_comb begin
        cnt_d      = 4'd0;
        last_com_d = last_com_q;
        acc_vld    = 1'b0;
        if (stable) begin
            cnt_d = (cnt_q == SETTLE_C) ? cnt_q : cnt_q + 4'd1;
        end
        if (settled) begin
            if (com_q == COM_BLANK) begin
                // A blank lets the same digit be accepted again afterwards.
                last_com_d = COM_BLANK;
            end else if (com_q != last_com_q) begin
                acc_vld    = 1'b1;
                last_com_d = com_q;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            com_q      <= COM_BLANK;
            ens_q      <= '0;
            prev_com_q <= COM_BLANK;
            prev_ens_q <= '0;
            cnt_q      <= 4'd0;
            last_com_q <= COM_BLANK;
        end else begin
            com_q      <= com_in;
            ens_q      <= ens_in;
            prev_com_q <= com_q;
            prev_ens_q <= ens_q;
            cnt_q      <= cnt_d;
            last_com_q <= last_com_d;
        end
    end

    assign acc_com = com_q;
    assign acc_ens = ens_q;

endmodule

// File: rtl/seg_scan_capture.sv
// Reassembles 8-digit seven-segment scans into 64-bit frames, flags sequence/COM errors and stalls.
// Latency: frame valid 1 cycle after the digit-7 accept; accept SETTLE+1 cycles after an input change.
// Backpressure: none; frame and error outputs are one-cycle pulses.
// Ports: clk, nrst | iS_COM (active-low select), iS_ENS (segments) | o_frame, o_frame_valid,
//        o_changed, o_seq_err, o_com_err, o_stall.
// Option: define SEG_CAPTURE_CHANGE_EN to keep a previous-frame copy and drive o_changed.
module seg_scan_capture
    import seg_scan_capture_pkg::*;
#(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  iS_COM,
    input  logic [7:0]  iS_ENS,
    output logic [63:0] o_frame,
    output logic        o_frame_valid,
    output logic        o_changed,
    output logic        o_seq_err,
    output logic        o_com_err,
    output logic        o_stall
);

    localparam int            IW   = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] TO_C = IW'(TIMEOUT);

    logic               acc_vld;
    logic [7:0]         acc_com;
    logic [DIGIT_W-1:0] acc_ens;
    com_dec_t           dec;

    state_e        state_q, state_d;
    logic [2:0]    exp_q, exp_d;
    frame_t        buf_q, buf_d;
    frame_t        frame_q, frame_d;
    logic          valid_q, valid_d;
    logic          seq_err_q, seq_err_d;
    logic          com_err_q, com_err_d;
    logic          stall_q, stall_d;
    logic [IW-1:0] idle_q, idle_d;

    seg_input_deglitch #(.SETTLE(SETTLE)) u_deglitch (
        .clk     (clk),
        .nrst    (nrst),
        .com_in  (iS_COM),
        .ens_in  (iS_ENS),
        .acc_vld (acc_vld),
        .acc_com (acc_com),
        .acc_ens (acc_ens)
    );

    assign dec = com_decode(acc_com);

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        buf_d     = buf_q;
        frame_d   = frame_q;
        valid_d   = 1'b0;
        seq_err_d = 1'b0;
        com_err_d = 1'b0;
        stall_d   = stall_q;
        idle_d    = idle_q;

        if (acc_vld) begin
            // An accept beats a coincident timeout.
            idle_d  = '0;
            stall_d = 1'b0;
            if (!dec.one_low) begin
                com_err_d = 1'b1;
                state_d   = SYNC;
            end else if (state_q == SYNC) begin
                if (dec.idx == 3'd0) begin
                    buf_d[0] = acc_ens;
                    exp_d    = 3'd1;
                    state_d  = COLLECT;
                end
            end else if (dec.idx == exp_q) begin
                buf_d[dec.idx] = acc_ens;
                exp_d          = exp_q + 3'd1;
                if (dec.idx == 3'd7) begin
                    frame_d = buf_d;
                    valid_d = 1'b1;
                    state_d = SYNC;
                end
            end else begin
                seq_err_d = 1'b1;
                if (dec.idx == 3'd0) begin
                    buf_d[0] = acc_ens;
                    exp_d    = 3'd1;
                    state_d  = COLLECT;
                end else begin
                    state_d = SYNC;
                end
            end
        end else begin
            if (idle_q != TO_C) begin
                idle_d = idle_q + IW'(1);
            end
            if (idle_d == TO_C) begin
                stall_d = 1'b1;
                state_d = SYNC;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= SYNC;
            exp_q     <= 3'd0;
            buf_q     <= '0;
            frame_q   <= '0;
            valid_q   <= 1'b0;
            seq_err_q <= 1'b0;
            com_err_q <= 1'b0;
            stall_q   <= 1'b0;
            idle_q    <= '0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            buf_q     <= buf_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
            seq_err_q <= seq_err_d;
            com_err_q <= com_err_d;
            stall_q   <= stall_d;
            idle_q    <= idle_d;
        end
    end

`ifdef SEG_CAPTURE_CHANGE_EN
    frame_t prev_frame_q, prev_frame_d;
    logic   changed_q, changed_d;

    always_comb begin
        prev_frame_d = prev_frame_q;
        changed_d    = 1'b0;
        if (valid_d) begin
            changed_d    = (frame_d != prev_frame_q);
            prev_frame_d = frame_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prev_frame_q <= '0;
            changed_q    <= 1'b0;
        end else begin
            prev_frame_q <= prev_frame_d;
            changed_q    <= changed_d;
        end
    end

    assign o_changed = changed_q;
`else
    assign o_changed = 1'b0;
`endif

    assign o_frame       = frame_q;
    assign o_frame_valid = valid_q;
    assign o_seq_err     = seq_err_q;
    assign o_com_err     = com_err_q;
    assign o_stall       = stall_q;

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Capture block for the multiplexed 8-digit seven-segment bus. It samples the common-select and segment lines produced by the display scanner, deglitches them, and reassembles one complete 8-digit frame per scan. Completed frames go out as a 64-bit word with a one-cycle valid pulse. It sits on the display side of the game top, either in the self-check bench or in an on-board readback path, and is the receiving end of the seven-segment scan interface.

## Interface
Parameters:
- SETTLE, 2: consecutive identical samples required before a digit is accepted (1..15).
- TIMEOUT, 4096: cycles without an accepted digit before the stall is declared (≥16).

Ports:
- clk  in  1  Single clock; one clock for the whole block.
- nrst  in  1  Reset, asynchronous, active-low.
- iS_COM  in  8  Digit select, active-low; bit i low selects digit i. All-high means blank.
- iS_ENS  in  8  Segment pattern of the selected digit, active-high.
- o_frame  out  64  Last completed frame; digit i occupies [8i+7:8i].
- o_frame_valid  out  1  One-cycle pulse when o_frame updates.
- o_changed  out  1  One-cycle pulse together with o_frame_valid when the new frame differs from the previous one (configurable).
- o_seq_err  out  1  One-cycle pulse on an out-of-order digit.
- o_com_err  out  1  One-cycle pulse on an accepted iS_COM with more than one low bit.
- o_stall  out  1  Level; high while no digit has been accepted for TIMEOUT cycles.

## Operation
- Input stage: iS_COM and iS_ENS are registered once. A stability counter increments while the registered pair equals its previous value and clears to 0 when the pair changes. It saturates at SETTLE.
- Accept event: occurs on the cycle the counter reaches SETTLE, only when iS_COM differs from the last accepted COM. A held digit is accepted once.
- Blank (COM = FF): never accepted and does not reset the sequence. It also clears the last accepted COM, so the same digit can be re-accepted after a blank.
- Multi-low COM: at acceptance, pulse o_com_err, discard the digit, go to SYNC.
- State machine:
  - SYNC: wait for an accepted digit 0. On digit 0: store it, expected index = 1, go to COLLECT. Any other digit is ignored silently.
  - COLLECT: accepted digit == expected: store it and increment expected.
    - Digit 7 stored: copy the working buffer to o_frame, pulse o_frame_valid, go to SYNC.
    - Accepted digit ≠ expected: pulse o_seq_err.
      - If that digit is 0: restart COLLECT with digit 0 stored.
      - Otherwise: go to SYNC.
- Working buffer is not cleared between frames; every frame is fully rewritten by the in-order rule.
- Timeout: idle counter clears on each accept event and saturates at TIMEOUT.
  - When it reaches TIMEOUT: set o_stall and force SYNC.
  - o_stall clears on the next accept event.

## Timing
- Reset values: o_frame = 0, all pulses 0, o_stall = 0, state SYNC, counters 0, last accepted COM = FF.
- Latency:
  - Input change to accept event: SETTLE+1 cycles (1 register stage plus SETTLE samples).
  - Digit 7 accept to o_frame_valid: 1 cycle. o_frame is valid in the same cycle as the pulse.
- Simultaneous events:
  - A timeout and an accept in the same cycle: the accept wins and o_stall stays 0.
  - o_com_err and o_seq_err are never both high.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is lost.

## Configuration
- SEG_CAPTURE_CHANGE_EN defined:
  - A 64-bit previous-frame register is kept, reset to 0.
  - o_changed pulses with o_frame_valid when the new frame ≠ the previous frame. The first frame after reset differs from 0 unless it is all zero.
- Not defined: no compare register; o_changed is tied to 0.

## Structure
- Shared package contents:
  - State enum (SYNC, COLLECT).
  - Constant COM_BLANK = 8'hFF.
  - Digit width 8 and digit count 8.
  - A function mapping one-low COM to a 3-bit index, with a one-hot-low check flag.
- One sub-module, seg_input_deglitch: registers the inputs, runs the stability counter, and produces the accept strobe, accepted COM and accepted ENS.

## Test plan
- Clean scan: digits 0..7 each held 4 cycles with ENS = 8'h10+i. Expected: one o_frame_valid with o_frame = 64'h17161514_13121110, no errors.
- Glitch: digit 3 COM held only 1 cycle inside the scan (SETTLE = 2). Expected: not accepted; next digit 4 triggers o_seq_err, FSM goes to SYNC, no frame that scan.
- Bad COM: COM = 8'hFC held 4 cycles. Expected: o_com_err one pulse, no frame; a subsequent clean scan produces a frame.
- Repeat with change: two identical clean scans, then a third with digit 5 = 8'h3F. Expected (macro defined): o_changed on frames 1 and 3 only; with the macro undefined, never.
- Stall: COM held at FF for TIMEOUT+2 cycles. Expected: o_stall rises at cycle TIMEOUT+1 after the last accept and falls on the next accepted digit 0.
- Reset mid-frame: nrst low after digit 4. Expected: o_frame = 0 and a fresh scan completes normally.
